// File: rtl/mips_shift_pkg.sv
// Shared constants and types for the MIPS variable-shift sequencer.
// ALU shift-by-1 codes, op encodings and FSM state enum.
package mips_shift_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  localparam logic [3:0] ALU_SLL1 = 4'b1000;
  localparam logic [3:0] ALU_SRL1 = 4'b1001;
  localparam logic [3:0] ALU_IDLE = 4'b0000;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  function automatic logic [3:0] alu_code(op_e op);
    return (op == OP_SLL) ? ALU_SLL1 : ALU_SRL1;
  endfunction

endpackage

// File: rtl/mips_shift_if.sv
// Pipeline/ALU side bundle of the shift sequencer.
// master = pipeline + ALU, slave = sequencer.
interface mips_shift_if #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
);

  logic               start_in;
  logic [1:0]         op_in;
  logic [SHAMT_W-1:0] shamt_in;
  logic [DATA_W-1:0]  data_in;
  logic [DATA_W-1:0]  ALU_result_in;
  logic [3:0]         ALUCntrl_out;
  logic [DATA_W-1:0]  B_out;
  logic               alu_req_out;
  logic               busy_out;
  logic               done_out;
  logic [DATA_W-1:0]  result_out;

  modport master (
    output start_in, op_in, shamt_in,
    output data_in, ALU_result_in,
    input  ALUCntrl_out, B_out, alu_req_out,
    input  busy_out, done_out, result_out
  );

  modport slave (
    input  start_in, op_in, shamt_in,
    input  data_in, ALU_result_in,
    output ALUCntrl_out, B_out, alu_req_out,
    output busy_out, done_out, result_out
  );

endinterface

// File: rtl/mips_shift_step_ctr.sv
// Loadable down-counter for remaining shift steps.
// last flags the final step (cnt == 1).
module mips_shift_step_ctr #(
  parameter int W = 5
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         last
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec)
      cnt <= cnt - 1'b1;
  end

  assign last = (cnt == W'(1));

endmodule

// File: rtl/mips_shift_seq.sv
// Multi-cycle sll/srl/sra sequencer driving ALU shift-by-1 steps.
// Define MIPS_SHIFT_SEQ_SRA_EN for sign-filling sra; else sra acts as srl.
module mips_shift_seq
  import mips_shift_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic         clk_in,
  input  logic         rst_in,
  mips_shift_if.slave  bus
);

  state_e            state;
  logic [DATA_W-1:0] work;
  logic [3:0]        ctrl_q;
  logic              alu_req_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] step_val;
  logic              accept;
  logic              last;

`ifdef MIPS_SHIFT_SEQ_SRA_EN
  op_e  op_q;
  logic sign_q;
`endif

  assign accept = (state == S_IDLE) && bus.start_in &&
                  (bus.op_in != OP_RSV);

  always_comb begin
    step_val = bus.ALU_result_in;
`ifdef MIPS_SHIFT_SEQ_SRA_EN
    // ALU only does logical shift-by-1; restore the sign bit here
    if (op_q == OP_SRA)
      step_val[DATA_W-1] = sign_q;
`endif
  end

  mips_shift_step_ctr #(.W(SHAMT_W)) u_ctr (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .load     (accept),
    .load_val (bus.shamt_in),
    .dec      (state == S_SHIFT),
    .last     (last)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= S_IDLE;
      work      <= '0;
      ctrl_q    <= ALU_IDLE;
      alu_req_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
`ifdef MIPS_SHIFT_SEQ_SRA_EN
      op_q      <= OP_SLL;
      sign_q    <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (accept) begin
            work   <= bus.data_in;
            busy_q <= 1'b1;
`ifdef MIPS_SHIFT_SEQ_SRA_EN
            op_q   <= op_e'(bus.op_in);
            sign_q <= bus.data_in[DATA_W-1];
`endif
            if (bus.shamt_in != '0) begin
              state     <= S_SHIFT;
              alu_req_q <= 1'b1;
              ctrl_q    <= alu_code(op_e'(bus.op_in));
            end else begin
              state    <= S_DONE;
              done_q   <= 1'b1;
              result_q <= bus.data_in;
            end
          end
        end
        S_SHIFT: begin
          work <= step_val;
          if (last) begin
            state     <= S_DONE;
            alu_req_q <= 1'b0;
            ctrl_q    <= ALU_IDLE;
            done_q    <= 1'b1;
            result_q  <= step_val;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ALUCntrl_out = ctrl_q;
  assign bus.B_out        = alu_req_q ? work : '0;
  assign bus.alu_req_out  = alu_req_q;
  assign bus.busy_out     = busy_q;
  assign bus.done_out     = done_q;
  assign bus.result_out   = result_q;

endmodule

// File: tb/tb_mips_shift_seq.sv
// Scoreboard bench for mips_shift_seq with an ALU model and
// an arithmetic reference model of sll/srl/sra.
module tb_mips_shift_seq;
  import mips_shift_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   alu_cnt = 0;
  int   busy_cnt = 0;

  typedef struct {
    logic [1:0]  op;
    int          n;
    logic [31:0] res;
    int          k;
  } exp_t;

  exp_t q[$];

  mips_shift_if bus ();

  mips_shift_seq dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #20 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  assign bus.ALU_result_in =
    (bus.ALUCntrl_out == 4'b1000) ? (bus.B_out << 1) :
    (bus.ALUCntrl_out == 4'b1001) ? (bus.B_out >> 1) : 32'h0;

  function automatic logic [31:0] ref_model(
    input logic [1:0] op, input int n, input logic [31:0] d);
    case (op)
      2'b00: return d << n;
      2'b01: return d >> n;
`ifdef MIPS_SHIFT_SEQ_SRA_EN
      2'b10: return $unsigned($signed(d) >>> n);
`else
      2'b10: return d >> n;
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cyc %0d)", name, cyc);
  endtask

  always @(negedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      alu_cnt  = 0;
      busy_cnt = 0;
    end else begin
      if (bus.busy_out) busy_cnt++;
      if (bus.alu_req_out) begin
        alu_cnt++;
        if (q.size() == 0)
          fail("alu_req_while_idle");
        else
          check("alu_ctrl", {28'h0, bus.ALUCntrl_out},
                (q[0].op == 2'b00) ? 32'h8 : 32'h9);
      end else begin
        check("ctrl_off", {28'h0, bus.ALUCntrl_out}, 32'h0);
        check("b_off", bus.B_out, 32'h0);
      end
      if (bus.done_out) begin
        if (q.size() == 0) begin
          fail("spurious_done");
        end else begin
          exp_t e;
          e = q.pop_front();
          check("result", bus.result_out, e.res);
          check("done_cycle", cyc, e.k + e.n);
          check("alu_cycles", alu_cnt, e.n);
          check("busy_cycles", busy_cnt, e.n + 1);
        end
        alu_cnt  = 0;
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [1:0] op, input int n,
                       input logic [31:0] d);
    int t;
    t = 0;
    @(negedge clk_in);
    while (bus.busy_out && t < 200) begin
      @(negedge clk_in);
      t++;
    end
    if (bus.busy_out) fail("busy_timeout");
    bus.start_in = 1'b1;
    bus.op_in    = op;
    bus.shamt_in = n[4:0];
    bus.data_in  = d;
    if (op != 2'b11)
      q.push_back('{op, n, ref_model(op, n, d), cyc + 1});
    @(negedge clk_in);
    bus.start_in = 1'b0;
    if (op == 2'b11)
      check("rsv_ignored", {31'h0, bus.busy_out}, 32'h0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk_in);
      t++;
    end
    if (q.size() != 0) fail("drain_timeout");
    repeat (4) @(negedge clk_in);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start_in = 1'b0;
    bus.op_in    = 2'b00;
    bus.shamt_in = '0;
    bus.data_in  = '0;
    repeat (2) @(negedge clk_in);
    check("rst_busy", {31'h0, bus.busy_out}, 32'h0);
    check("rst_done", {31'h0, bus.done_out}, 32'h0);
    check("rst_req", {31'h0, bus.alu_req_out}, 32'h0);
    check("rst_result", bus.result_out, 32'h0);
    check("rst_b", bus.B_out, 32'h0);
    rst_in = 1'b0;

    issue(2'b00, 4, 32'h0000_000F);
    drain();
    check("sll4_held", bus.result_out, 32'h0000_00F0);
    issue(2'b01, 31, 32'h8000_0000);
    drain();
    check("srl31_held", bus.result_out, 32'h0000_0001);
    issue(2'b00, 0, 32'hDEAD_BEEF);
    drain();
    check("sh0_held", bus.result_out, 32'hDEAD_BEEF);
    issue(2'b10, 4, 32'hF000_0000);
    drain();

    // start pulse mid-shift must not disturb or queue
    issue(2'b00, 10, 32'h1234_5678);
    @(negedge clk_in);
    bus.start_in = 1'b1;
    bus.op_in    = 2'b01;
    bus.shamt_in = 5'd3;
    bus.data_in  = 32'hFFFF_FFFF;
    @(negedge clk_in);
    bus.start_in = 1'b0;
    drain();

    issue(2'b11, 5, 32'hCAFE_F00D);
    drain();

    // reset in the third SHIFT cycle of a 10-step srl
    issue(2'b01, 10, 32'hA5A5_5A5A);
    repeat (2) @(negedge clk_in);
    #5 rst_in = 1'b1;
    #1;
    check("mid_rst_busy", {31'h0, bus.busy_out}, 32'h0);
    check("mid_rst_done", {31'h0, bus.done_out}, 32'h0);
    check("mid_rst_req", {31'h0, bus.alu_req_out}, 32'h0);
    check("mid_rst_ctrl", {28'h0, bus.ALUCntrl_out}, 32'h0);
    check("mid_rst_b", bus.B_out, 32'h0);
    check("mid_rst_result", bus.result_out, 32'h0);
    q.delete();
    @(posedge clk_in);
    #5 rst_in = 1'b0;
    issue(2'b00, 7, 32'h0000_0101);
    drain();

    repeat (40) begin
      logic [1:0]  op;
      int          n;
      logic [31:0] d;
      op = 2'($urandom_range(0, 3));
      n  = int'($urandom_range(0, 31));
      d  = $urandom;
      issue(op, n, d);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
